// File: rtl/csc_matrix_3x3.sv
//------------------------------------------------------------------------------
// Module   : csc_matrix_3x3
// Purpose  : Programmable 3x3 colour-space converter with per-row offsets,
//            round-half-up and saturation. The coefficient bank is double
//            buffered. Shadow writes reach the active bank only at an input
//            vsync rising edge, so a frame is never converted with a mix of
//            two banks. Reset defaults give BT.601 full-range RGB->YCbCr.
// Ports    : clk, rst          - pixel clock, synchronous active-high reset
//            ce                - 1 = convert (3-cycle latency), 0 = bypass
//            in_data           - {c0, c2, c1}, c0 in the MSBs
//            in_hsync/vsync/de - input video timing
//            cfg_we/addr/data  - shadow bank write port (addr 0..8 M, 9..11 off)
//            cfg_commit        - request shadow->active at next vsync rise
//            cfg_pending       - a commit is waiting for its vsync rise
//            out_data          - {o0, o1, o2}, o0 in the MSBs
//            out_hsync/vsync/de- timing delayed to match out_data
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csc_matrix_3x3 #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [3*DATA_W-1:0]   in_data,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [COEF_W-1:0]     cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_pending,
  output logic [3*DATA_W-1:0]   out_data,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic                  out_de
);

  localparam int PROD_W = COEF_W + DATA_W + 1;
  localparam int ACC_W  = COEF_W + DATA_W + 3;
  localparam int OFF_W  = DATA_W + 1;
  // Default constants are tabulated at 16 fractional bits; rescale to COEF_FRAC.
  localparam int UP_SH  = (COEF_FRAC >= 16) ? COEF_FRAC - 16 : 0;
  localparam int DN_SH  = (COEF_FRAC < 16) ? 16 - COEF_FRAC : 0;
  localparam logic [ACC_W-1:0] ROUND = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);

  // Round-to-nearest rescale: floor(v*2^UP/2^DN + 1/2) = (2v' + 2^DN) >>> (DN+1).
  function automatic logic signed [COEF_W-1:0] default_coef(input int idx);
    longint base;
    longint scaled;
    case (idx)
      0:       base = 19595;
      1:       base = 38470;
      2:       base = 7471;
      3:       base = -11059;
      4:       base = -21709;
      5:       base = 32768;
      6:       base = 32768;
      7:       base = -27439;
      default: base = -5329;
    endcase
    scaled = ((base <<< UP_SH) * 2 + (longint'(1) <<< DN_SH)) >>> (DN_SH + 1);
    return COEF_W'(scaled);
  endfunction

  function automatic logic signed [OFF_W-1:0] default_off(input int idx);
    logic signed [OFF_W-1:0] v;
    v = '0;
    if (idx != 0) v[DATA_W-1] = 1'b1;   // mid-scale for the chroma rows
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Coefficient banks and commit control
  // ---------------------------------------------------------------------------
  logic signed [COEF_W-1:0] shadow_coef [9];
  logic signed [COEF_W-1:0] active_coef [9];
  logic signed [OFF_W-1:0]  shadow_off  [3];
  logic signed [OFF_W-1:0]  active_off  [3];

  logic [2:0] sync_d1, sync_d2, sync_d3;   // {vsync, hsync, de}
  logic       vsync_rise;
  logic       swap;
  logic [1:0] off_idx;

  // sync_d1[2] doubles as the previous in_vsync for edge detection.
  assign vsync_rise = in_vsync & ~sync_d1[2];
  assign swap       = vsync_rise & (cfg_pending | cfg_commit);
  assign off_idx    = 2'(cfg_addr - 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        shadow_coef[i] <= default_coef(i);
        active_coef[i] <= default_coef(i);
      end
      for (int i = 0; i < 3; i++) begin
        shadow_off[i] <= default_off(i);
        active_off[i] <= default_off(i);
      end
      cfg_pending <= 1'b0;
    end else begin
      // Active takes the pre-edge shadow, so a same-edge write is not copied.
      if (swap) begin
        active_coef <= shadow_coef;
        active_off  <= shadow_off;
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
      if (cfg_we) begin
        if (cfg_addr <= 4'd8) begin
          shadow_coef[cfg_addr] <= cfg_data;
        end else if (cfg_addr <= 4'd11) begin
          shadow_off[off_idx] <= cfg_data[OFF_W-1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]        comp    [3];
  logic signed [PROD_W-1:0] prod_c  [9];
  logic signed [PROD_W-1:0] prod    [9];
  logic signed [OFF_W-1:0]  off_s1  [3];
  logic signed [ACC_W-1:0]  sum_a_c [3];
  logic signed [ACC_W-1:0]  sum_b_c [3];
  logic signed [ACC_W-1:0]  sum_a   [3];
  logic signed [ACC_W-1:0]  sum_b   [3];
  logic signed [ACC_W-1:0]  total   [3];
  logic signed [ACC_W-1:0]  shifted [3];
  logic [DATA_W-1:0]        sat_c   [3];
  logic [DATA_W-1:0]        res     [3];

  // in_data carries R,B,G; comp[] is reordered to c0,c1,c2 to match M's columns.
  assign comp[0] = in_data[3*DATA_W-1 -: DATA_W];
  assign comp[1] = in_data[DATA_W-1:0];
  assign comp[2] = in_data[2*DATA_W-1 -: DATA_W];

  // S1 products: signed coefficient times zero-extended component.
  always_comb begin
    for (int n = 0; n < 9; n++) begin
      prod_c[n] = {{(PROD_W-COEF_W){active_coef[n][COEF_W-1]}}, active_coef[n]}
                * {{(PROD_W-DATA_W){1'b0}}, comp[n % 3]};
    end
  end

  // S2 partial sums; the offset is aligned to the coefficient binary point.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sum_a_c[k] = {{(ACC_W-PROD_W){prod[3*k][PROD_W-1]}},   prod[3*k]}
                 + {{(ACC_W-PROD_W){prod[3*k+1][PROD_W-1]}}, prod[3*k+1]};
      sum_b_c[k] = {{(ACC_W-PROD_W){prod[3*k+2][PROD_W-1]}}, prod[3*k+2]}
                 + ({{(ACC_W-OFF_W){off_s1[k][OFF_W-1]}}, off_s1[k]} <<< COEF_FRAC);
    end
  end

  // S3 round half up, drop fraction, clamp to the unsigned component range.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      total[k]   = sum_a[k] + sum_b[k] + ROUND;
      shifted[k] = total[k] >>> COEF_FRAC;
      if (total[k][ACC_W-1]) begin
        sat_c[k] = '0;
      end else if (|shifted[k][ACC_W-1:DATA_W]) begin
        sat_c[k] = '1;
      end else begin
        sat_c[k] = shifted[k][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) prod[n] <= '0;
      for (int k = 0; k < 3; k++) begin
        off_s1[k] <= '0;
        sum_a[k]  <= '0;
        sum_b[k]  <= '0;
        res[k]    <= '0;
      end
      sync_d1 <= '0;
      sync_d2 <= '0;
      sync_d3 <= '0;
    end else begin
      for (int n = 0; n < 9; n++) prod[n] <= prod_c[n];
      // Offsets travel with their products so a row never mixes banks.
      for (int k = 0; k < 3; k++) begin
        off_s1[k] <= active_off[k];
        sum_a[k]  <= sum_a_c[k];
        sum_b[k]  <= sum_b_c[k];
        res[k]    <= sat_c[k];
      end
      sync_d1 <= {in_vsync, in_hsync, in_de};
      sync_d2 <= sync_d1;
      sync_d3 <= sync_d2;
    end
  end

  assign out_data  = ce ? {res[0], res[1], res[2]} : in_data;
  assign out_vsync = ce ? sync_d3[2] : in_vsync;
  assign out_hsync = ce ? sync_d3[1] : in_hsync;
  assign out_de    = ce ? sync_d3[0] : in_de;

endmodule

`default_nettype wire
